// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED controller: register offsets, display modes,
// bus handshake states and the single-step rotate helper used by the pattern engine.
package led_ctrl_pkg;

    // Register offsets within the 4-word block (bus_addr[1:0]).
    localparam logic [1:0] OfsData = 2'd0;
    localparam logic [1:0] OfsCtrl = 2'd1;
    localparam logic [1:0] OfsDiv  = 2'd2;
    localparam logic [1:0] OfsStat = 2'd3;

    // Reset value of the tick divider register.
    localparam logic [15:0] DivReset = 16'h00FF;

    // Display modes held in CTRL[1:0].
    typedef enum logic [1:0] {
        ModeStatic = 2'd0,
        ModeBlink  = 2'd1,
        ModeRotL   = 2'd2,
        ModeRotR   = 2'd3
    } led_mode_e;

    // Bus handshake: one accept cycle followed by one ack cycle.
    typedef enum logic {
        StIdle = 1'b0,
        StAck  = 1'b1
    } bus_state_e;

    // Rotate a 16-bit pattern by one position; bit 15 and bit 0 wrap into each other.
    function automatic logic [15:0] rot1(input logic [15:0] v, input logic left);
        logic [15:0] r;
        if (left) begin
            r = {v[14:0], v[15]};
        end else begin
            r = {v[0], v[15:1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Programmable tick generator for the LED controller.
// A free-running prescaler of 2^TICK_PRE cycles advances a divider counter on each wrap;
// tick pulses for one cycle on the prescaler wrap where the divider count has reached div,
// and the divider count then restarts from zero.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   clr  - synchronous clear of both counters (takes priority over counting)
//   div  - divider setting; tick period = (div+1) * 2^TICK_PRE cycles
//   tick - one-cycle tick pulse
module led_tick_gen #(
    parameter int unsigned TICK_PRE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [15:0] div,
    output logic        tick
);

    localparam logic [TICK_PRE-1:0] PreOne = TICK_PRE'(1);

    logic [TICK_PRE-1:0] pre_q, pre_d;
    logic [15:0]         div_cnt_q, div_cnt_d;
    logic                pre_wrap;

    always_comb begin
        pre_wrap  = &pre_q;
        // >= rather than == so that lowering div below the running count ticks at the
        // next prescaler wrap instead of waiting for the 16-bit counter to roll over.
        tick      = pre_wrap && (div_cnt_q >= div);
        pre_d     = pre_q + PreOne;
        div_cnt_d = div_cnt_q;
        if (pre_wrap) begin
            div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
        end
        if (clr) begin
            pre_d     = '0;
            div_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q     <= '0;
            div_cnt_q <= 16'd0;
        end else begin
            pre_q     <= pre_d;
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// Memory-mapped LED peripheral. Decodes a 4-word register block on the CPU data bus,
// holds the DATA/CTRL/DIV registers and drives a registered display pattern that is
// static, blinking or rotating (marquee) at the rate of the tick generator.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   bus_en    - access request
//   bus_we    - 1 = write, 0 = read (qualified by bus_en)
//   bus_addr  - word address; block decodes BASE_ADDR[15:2]
//   bus_wdata - write data
//   bus_rdata - read data, valid while bus_ack = 1 (holds otherwise)
//   bus_ack   - one-cycle completion pulse, the cycle after an accepted access
//   led_data  - registered display pattern
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hBF20,
    parameter int unsigned TICK_PRE  = 16,
    parameter logic [15:0] RESET_PAT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_en,
    input  logic        bus_we,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        bus_ack,
    output logic [15:0] led_data
);

    bus_state_e  state_q, state_d;
    logic [15:0] data_q, data_d;
    led_mode_e   mode_q, mode_d;
    logic [15:0] div_q, div_d;
    logic [15:0] work_q, work_d;
    logic        phase_q, phase_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;

    logic        hit;
    logic        accept;
    logic        wr;
    logic        rd;
    logic [1:0]  ofs;
    logic        restart;
    logic        clr;
    logic        tick;

    led_tick_gen #(
        .TICK_PRE (TICK_PRE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .div  (div_q),
        .tick (tick)
    );

    // Decode and bus handshake.
    always_comb begin
        hit     = (bus_addr[15:2] == BASE_ADDR[15:2]);
        // No new access while the previous one is being acked, so held requests complete
        // every second cycle.
        accept  = bus_en && hit && (state_q == StIdle);
        wr      = accept && bus_we;
        rd      = accept && !bus_we;
        ofs     = bus_addr[1:0];

        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StAck;
            StAck:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Register writes, read capture and pattern engine.
    always_comb begin
        data_d  = data_q;
        mode_d  = mode_q;
        div_d   = div_q;
        work_d  = work_q;
        phase_d = phase_q;
        rdata_d = rdata_q;
        restart = 1'b0;
        clr     = 1'b0;

        if (wr) begin
            case (ofs)
                OfsData: begin
                    data_d  = bus_wdata;
                    restart = 1'b1;
                end
                OfsCtrl: begin
                    mode_d  = led_mode_e'(bus_wdata[1:0]);
                    restart = 1'b1;
                end
                OfsDiv: begin
                    div_d = bus_wdata;
                    clr   = 1'b1;
                end
                default: ; // STAT is read-only; the write is acked and dropped
            endcase
        end

        if (rd) begin
            case (ofs)
                OfsData: rdata_d = data_q;
                OfsCtrl: rdata_d = {14'd0, mode_q};
                OfsDiv:  rdata_d = div_q;
                default: rdata_d = led_q;
            endcase
        end

        if (restart) begin
            // Reload from the value being written so a DATA write is visible immediately.
            work_d  = data_d;
            phase_d = 1'b1;
            clr     = 1'b1;
        end else if (tick && !clr) begin
            // A tick coinciding with a counter-clearing write is dropped.
            unique case (mode_q)
                ModeStatic: ;
                ModeBlink:  phase_d = !phase_q;
                ModeRotL:   work_d  = rot1(work_q, 1'b1);
                ModeRotR:   work_d  = rot1(work_q, 1'b0);
                default:    ;
            endcase
        end

        unique case (mode_q)
            ModeStatic: led_d = data_q;
            ModeBlink:  led_d = phase_q ? data_q : 16'h0000;
            ModeRotL:   led_d = work_q;
            ModeRotR:   led_d = work_q;
            default:    led_d = data_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            data_q  <= RESET_PAT;
            mode_q  <= ModeStatic;
            div_q   <= DivReset;
            work_q  <= RESET_PAT;
            phase_q <= 1'b1;
            rdata_q <= 16'h0000;
            led_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            work_q  <= work_d;
            phase_q <= phase_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
        end
    end

    assign bus_ack   = (state_q == StAck);
    assign bus_rdata = rdata_q;
    assign led_data  = led_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl with a 4-cycle prescaler (TICK_PRE = 2).
module tb_led_ctrl;

    localparam logic [15:0] Base = 16'hBF20;

    logic        clk;
    logic        rst;
    logic        bus_en;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;
    logic [15:0] led_data;

    int checks;
    int failures;

    // Scoreboards: expected read data and expected per-cycle display values.
    logic [15:0] rd_exp[$];
    logic [15:0] led_exp[$];

    led_ctrl #(
        .BASE_ADDR (Base),
        .TICK_PRE  (2),
        .RESET_PAT (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_en    (bus_en),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .led_data  (led_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] rot_by(input logic [15:0] v, input int k, input bit left);
        int s;
        s = k % 16;
        if (s == 0) return v;
        if (left) return (v << s) | (v >> (16 - s));
        return (v >> s) | (v << (16 - s));
    endfunction

    // One access: request for one edge, then sample ack/rdata at the following negedge.
    // Waits out a pending ack first so consecutive calls are accepted.
    task automatic bus_xfer(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            output logic ack, output logic [15:0] rdata);
        if (bus_ack) @(negedge clk);
        bus_en    = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wdata;
        @(posedge clk);
        #1;
        bus_en = 1'b0;
        bus_we = 1'b0;
        @(negedge clk);
        ack   = bus_ack;
        rdata = bus_rdata;
    endtask

    task automatic test_reset();
        logic        ack;
        logic [15:0] rdata;
        logic [15:0] want;
        rst = 1'b0;
        bus_en = 1'b0; bus_we = 1'b0; bus_addr = 16'h0000; bus_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if (led_data !== 16'h0000 || bus_ack !== 1'b0 || bus_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state: led=%h ack=%b rdata=%h want 0000/0/0000",
                     led_data, bus_ack, bus_rdata);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (led_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_led_after_release: got %h want 0000", led_data);
        end
        rd_exp.push_back(16'h0000);
        rd_exp.push_back(16'h0000);
        rd_exp.push_back(16'h00FF);
        rd_exp.push_back(16'h0000);
        for (int i = 0; i < 4; i++) begin
            bus_xfer(1'b0, Base + 16'(i), 16'h0000, ack, rdata);
            want = rd_exp.pop_front();
            checks++;
            if (ack !== 1'b1 || rdata !== want) begin
                failures++;
                $display("FAIL reset_read ofs%0d: ack=%b rdata=%h want 1/%h", i, ack, rdata, want);
            end
        end
    endtask

    task automatic test_static();
        logic        ack;
        logic [15:0] rdata;
        logic [15:0] want;
        bus_xfer(1'b1, Base + 16'd0, 16'hA5A5, ack, rdata);
        checks++;
        if (ack !== 1'b1 || led_data !== 16'h0000) begin
            failures++;
            $display("FAIL static_ack: ack=%b led=%h want 1/0000", ack, led_data);
        end
        @(negedge clk);
        checks++;
        if (led_data !== 16'hA5A5) begin
            failures++;
            $display("FAIL static_led: got %h want A5A5", led_data);
        end
        rd_exp.push_back(16'hA5A5);
        rd_exp.push_back(16'hA5A5);
        rd_exp.push_back(16'h0000);
        bus_xfer(1'b0, Base + 16'd0, 16'h0000, ack, rdata);
        want = rd_exp.pop_front();
        checks++;
        if (ack !== 1'b1 || rdata !== want) begin
            failures++;
            $display("FAIL static_read_data: ack=%b rdata=%h want 1/%h", ack, rdata, want);
        end
        bus_xfer(1'b0, Base + 16'd3, 16'h0000, ack, rdata);
        want = rd_exp.pop_front();
        checks++;
        if (ack !== 1'b1 || rdata !== want) begin
            failures++;
            $display("FAIL static_read_stat: ack=%b rdata=%h want 1/%h", ack, rdata, want);
        end
        bus_xfer(1'b0, Base + 16'd1, 16'h0000, ack, rdata);
        want = rd_exp.pop_front();
        checks++;
        if (ack !== 1'b1 || rdata !== want) begin
            failures++;
            $display("FAIL static_read_ctrl: ack=%b rdata=%h want 1/%h", ack, rdata, want);
        end
    endtask

    task automatic test_blink();
        logic        ack;
        logic [15:0] rdata;
        logic [15:0] want;
        bus_xfer(1'b1, Base + 16'd2, 16'h0001, ack, rdata);
        // Upper CTRL bits are written as ones; they must read back as zero.
        bus_xfer(1'b1, Base + 16'd1, 16'hFFFD, ack, rdata);
        for (int n = 1; n <= 24; n++) begin
            led_exp.push_back((((n - 1) / 8) % 2 == 0) ? 16'hA5A5 : 16'h0000);
        end
        for (int n = 1; led_exp.size() > 0; n++) begin
            @(negedge clk);
            want = led_exp.pop_front();
            checks++;
            if (led_data !== want) begin
                failures++;
                $display("FAIL blink cycle %0d: led=%h want %h", n, led_data, want);
            end
        end
        rd_exp.push_back(16'h0001);
        bus_xfer(1'b0, Base + 16'd1, 16'h0000, ack, rdata);
        want = rd_exp.pop_front();
        checks++;
        if (ack !== 1'b1 || rdata !== want) begin
            failures++;
            $display("FAIL blink_ctrl_readback: ack=%b rdata=%h want 1/%h", ack, rdata, want);
        end
    endtask

    task automatic test_rotate(input bit left, input int cycles);
        logic        ack;
        logic [15:0] rdata;
        logic [15:0] want;
        bus_xfer(1'b1, Base + 16'd0, 16'h0001, ack, rdata);
        bus_xfer(1'b1, Base + 16'd2, 16'h0000, ack, rdata);
        bus_xfer(1'b1, Base + 16'd1, left ? 16'h0002 : 16'h0003, ack, rdata);
        for (int n = 1; n <= cycles; n++) led_exp.push_back(rot_by(16'h0001, (n - 1) / 4, left));
        for (int n = 1; led_exp.size() > 0; n++) begin
            @(negedge clk);
            want = led_exp.pop_front();
            checks++;
            if (led_data !== want) begin
                failures++;
                $display("FAIL rotate_%s cycle %0d: led=%h want %h",
                         left ? "left" : "right", n, led_data, want);
            end
        end
    endtask

    task automatic test_write_on_tick();
        logic        ack;
        logic [15:0] rdata;
        logic [15:0] want;
        // DATA=0001, DIV=0 from the previous test; restart rotate-left.
        bus_xfer(1'b1, Base + 16'd1, 16'h0002, ack, rdata);
        repeat (3) @(negedge clk);
        // Accept edge lands exactly on the fourth edge, where a tick is due.
        bus_xfer(1'b1, Base + 16'd0, 16'h00F0, ack, rdata);
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL tick_write_ack: got %b want 1", ack);
        end
        led_exp.push_back(16'h0001);
        for (int n = 0; n < 4; n++) led_exp.push_back(16'h00F0);
        for (int n = 0; n < 4; n++) led_exp.push_back(16'h01E0);
        want = led_exp.pop_front();
        checks++;
        if (led_data !== want) begin
            failures++;
            $display("FAIL tick_write_led at ack: led=%h want %h", led_data, want);
        end
        for (int n = 1; led_exp.size() > 0; n++) begin
            @(negedge clk);
            want = led_exp.pop_front();
            checks++;
            if (led_data !== want) begin
                failures++;
                $display("FAIL tick_write cycle %0d: led=%h want %h", n, led_data, want);
            end
        end
    endtask

    task automatic test_decode_miss();
        logic        ack;
        logic [15:0] rdata;
        logic [15:0] want;
        logic [15:0] last;
        bus_xfer(1'b0, Base + 16'd1, 16'h0000, ack, rdata);
        last = 16'h0002;
        checks++;
        if (ack !== 1'b1 || rdata !== last) begin
            failures++;
            $display("FAIL miss_pre_read: ack=%b rdata=%h want 1/%h", ack, rdata, last);
        end
        bus_xfer(1'b1, Base + 16'd4, 16'h1234, ack, rdata);
        checks++;
        if (ack !== 1'b0 || rdata !== last) begin
            failures++;
            $display("FAIL miss_above: ack=%b rdata=%h want 0/%h", ack, rdata, last);
        end
        bus_xfer(1'b1, Base - 16'd1, 16'h5678, ack, rdata);
        checks++;
        if (ack !== 1'b0 || rdata !== last) begin
            failures++;
            $display("FAIL miss_below: ack=%b rdata=%h want 0/%h", ack, rdata, last);
        end
        bus_xfer(1'b0, Base + 16'd4, 16'h0000, ack, rdata);
        checks++;
        if (ack !== 1'b0 || rdata !== last) begin
            failures++;
            $display("FAIL miss_read_holds: ack=%b rdata=%h want 0/%h", ack, rdata, last);
        end
        bus_xfer(1'b1, Base + 16'd3, 16'hFFFF, ack, rdata);
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL stat_write_ack: got %b want 1", ack);
        end
        rd_exp.push_back(16'h00F0);
        rd_exp.push_back(16'h0002);
        rd_exp.push_back(16'h0000);
        for (int i = 0; i < 3; i++) begin
            bus_xfer(1'b0, Base + 16'(i), 16'h0000, ack, rdata);
            want = rd_exp.pop_front();
            checks++;
            if (ack !== 1'b1 || rdata !== want) begin
                failures++;
                $display("FAIL miss_unchanged ofs%0d: ack=%b rdata=%h want 1/%h",
                         i, ack, rdata, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        want_ack;
        logic [15:0] want;
        if (bus_ack) @(negedge clk);
        bus_en   = 1'b1;
        bus_we   = 1'b0;
        bus_addr = Base + 16'd0;
        rd_exp.push_back(16'h00F0);
        rd_exp.push_back(16'h00F0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            want_ack = (i % 2 == 0);
            checks++;
            if (bus_ack !== want_ack) begin
                failures++;
                $display("FAIL b2b_ack cycle %0d: ack=%b want %b", i, bus_ack, want_ack);
            end
            if (want_ack) begin
                want = rd_exp.pop_front();
                checks++;
                if (bus_rdata !== want) begin
                    failures++;
                    $display("FAIL b2b_rdata cycle %0d: rdata=%h want %h", i, bus_rdata, want);
                end
            end
        end
        bus_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_rotate();
        logic        ack;
        logic [15:0] rdata;
        logic [15:0] want;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (led_data !== 16'h0000 || bus_ack !== 1'b0 || bus_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset: led=%h ack=%b rdata=%h want 0000/0/0000",
                     led_data, bus_ack, bus_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        rd_exp.push_back(16'h0000);
        rd_exp.push_back(16'h0000);
        rd_exp.push_back(16'h00FF);
        for (int i = 0; i < 3; i++) begin
            bus_xfer(1'b0, Base + 16'(i), 16'h0000, ack, rdata);
            want = rd_exp.pop_front();
            checks++;
            if (ack !== 1'b1 || rdata !== want) begin
                failures++;
                $display("FAIL post_reset_read ofs%0d: ack=%b rdata=%h want 1/%h",
                         i, ack, rdata, want);
            end
        end
        checks++;
        if (led_data !== 16'h0000) begin
            failures++;
            $display("FAIL post_reset_led: got %h want 0000", led_data);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_static();
        test_blink();
        test_rotate(1'b1, 68);
        test_rotate(1'b0, 12);
        test_write_on_tick();
        test_decode_miss();
        test_back_to_back();
        test_reset_mid_rotate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
